// File: rtl/led_bank_loader_pkg.sv
// -----------------------------------------------------------------------------
// led_bank_loader_pkg
// Shared types and helpers for the LED bank loader.
//   loader_state_e : loader FSM states (lamp test, clear, idle)
//   bank_width(n)  : width of a bank index for n banks, never less than 1
// -----------------------------------------------------------------------------
package led_bank_loader_pkg;

    typedef enum logic [1:0] {
        LOADER_TEST  = 2'd0,
        LOADER_CLEAR = 2'd1,
        LOADER_IDLE  = 2'd2
    } loader_state_e;

    function automatic int bank_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_bank_loader_hold_timer.sv
// -----------------------------------------------------------------------------
// led_hold_timer
// Down-counter pacing the lamp-test steps. While count_i is high, done_o
// pulses once every HOLD_CYCLES cycles. A count of zero means "start of a
// step": the next counting edge reloads HOLD_CYCLES-1, so reset (count=0)
// and step boundaries behave identically.
// Ports:
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset (count returns to 0)
//   count_i : advance the timer this cycle
//   done_o  : high in the last cycle of each HOLD_CYCLES period
// -----------------------------------------------------------------------------
module led_hold_timer #(
    parameter int HOLD_CYCLES = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic count_i,
    output logic done_o
);
    localparam int CW      = $clog2(HOLD_CYCLES + 1);
    // With a one-cycle hold the counter never leaves zero.
    localparam int DONE_AT = (HOLD_CYCLES == 1) ? 0 : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign done_o = count_i && (cnt_q == CW'(DONE_AT));

    always_comb begin
        cnt_d = cnt_q;
        if (count_i) begin
            if (done_o) begin
                cnt_d = '0;
            end else if (cnt_q == '0) begin
                cnt_d = CW'(HOLD_CYCLES - 1);
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_bank_loader.sv
// -----------------------------------------------------------------------------
// led_bank_loader
// Front end for a NUM_BANKS x WIDTH array of reset-less enable-flop LED cells.
// Accepts (bank, data) writes over valid/ready and produces a registered
// one-cycle row-enable pulse plus shared data. After reset it clears every
// row; optional lamp test walks a single lit bit across all rows first.
// Build option: define LED_SELFTEST_EN to include the lamp test.
// Ports:
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   req_valid_i/ready_o    : write handshake
//   req_bank_i, req_data_i : target row and its data
//   clr_i                  : clear all rows (wins over a pending request)
//   en_o                   : per-row enable (one-hot or all ones)
//   d_o                    : data shared by all rows
//   err_o                  : pulse when an out-of-range write is dropped
// -----------------------------------------------------------------------------
module led_bank_loader
    import led_bank_loader_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int NUM_BANKS   = 4,
    parameter int HOLD_CYCLES = 1000,
    localparam int BW         = bank_width(NUM_BANKS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [BW-1:0]        req_bank_i,
    input  logic [WIDTH-1:0]     req_data_i,
    input  logic                 clr_i,
    output logic [NUM_BANKS-1:0] en_o,
    output logic [WIDTH-1:0]     d_o,
    output logic                 err_o
);

    loader_state_e        state_q, state_d;
    logic [NUM_BANKS-1:0] en_q, en_d;
    logic [WIDTH-1:0]     d_q, d_d;
    logic                 err_q, err_d;
    logic                 accept;
    logic                 in_range;

`ifdef LED_SELFTEST_EN
    localparam loader_state_e RESET_STATE = LOADER_TEST;
    localparam int STEP_W = bank_width(WIDTH);

    logic [STEP_W-1:0] step_q, step_d;
    logic              hold_done;

    led_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .count_i (state_q == LOADER_TEST),
        .done_o  (hold_done)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end
`else
    localparam loader_state_e RESET_STATE = LOADER_CLEAR;

    // Hold time only matters for the lamp test; keep the parameter referenced.
    if (HOLD_CYCLES >= 1) begin : g_no_selftest
    end
`endif

    // Ready also drops while reset is asserted so nothing is accepted then.
    assign req_ready_o = rst_ni && (state_q == LOADER_IDLE) && !clr_i;
    assign accept      = req_valid_i && req_ready_o;
    // Extra bit so the bound NUM_BANKS is representable when it is 2**BW.
    assign in_range    = ({1'b0, req_bank_i} < (BW + 1)'(NUM_BANKS));

    always_comb begin
        state_d = state_q;
        en_d    = '0;
        d_d     = '0;
        err_d   = 1'b0;
`ifdef LED_SELFTEST_EN
        step_d  = step_q;
`endif
        case (state_q)
`ifdef LED_SELFTEST_EN
            LOADER_TEST: begin
                en_d = '1;
                d_d  = WIDTH'(1) << step_q;
                if (hold_done) begin
                    if (step_q == STEP_W'(WIDTH - 1)) begin
                        step_d  = '0;
                        state_d = LOADER_CLEAR;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
`endif
            LOADER_CLEAR: begin
                en_d    = '1;
                state_d = LOADER_IDLE;
            end
            LOADER_IDLE: begin
                if (clr_i) begin
                    en_d = '1;
                end else if (accept) begin
                    if (in_range) begin
                        en_d = NUM_BANKS'(1) << req_bank_i;
                        d_d  = req_data_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOADER_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RESET_STATE;
            en_q    <= '0;
            d_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            d_q     <= d_d;
            err_q   <= err_d;
        end
    end

    assign en_o  = en_q;
    assign d_o   = d_q;
    assign err_o = err_q;

endmodule
